// File: rtl/wb_sram_burst_slave_if.sv
// Wishbone B4 bus bundle for the SRAM burst slave.
// The master modport drives requests and the slave modport drives responses.
interface wb_sram_burst_slave_if #(
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned WB_DATA_WIDTH = 32
);
  logic [WB_ADDR_WIDTH-1:0]   ADR;
  logic [WB_DATA_WIDTH-1:0]   DAT_W;
  logic [WB_DATA_WIDTH-1:0]   DAT_R;
  logic [WB_DATA_WIDTH/8-1:0] SEL;
  logic                       CYC;
  logic                       STB;
  logic                       WE;
  logic [2:0]                 CTI;
  logic [1:0]                 BTE;
  logic                       ACK;
  logic                       ERR;

  modport master (
    output ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE,
    input  DAT_R, ACK, ERR
  );

  modport slave (
    input  ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE,
    output DAT_R, ACK, ERR
  );
endinterface

// File: rtl/wb_sram_burst_slave.sv
// Wishbone B4 slave backed by on-chip synchronous SRAM: classic cycles,
// registered-feedback incrementing/wrapping bursts, ERR outside its window.
module wb_sram_burst_slave #(
  parameter int unsigned              WB_ADDR_WIDTH = 32,
  parameter int unsigned              WB_DATA_WIDTH = 32,
  parameter int unsigned              MEM_ADDR_BITS = 10,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = '0
) (
  input logic                  clk,
  input logic                  rstn,
  wb_sram_burst_slave_if.slave wb
);

  localparam int unsigned              NB      = WB_DATA_WIDTH / 8;
  localparam int unsigned              OFF     = $clog2(NB);
  localparam int unsigned              DEPTH   = 2 ** MEM_ADDR_BITS;
  localparam logic [WB_ADDR_WIDTH-1:0] DEPTH_W = WB_ADDR_WIDTH'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ACK_CLASSIC,
    BURST,
    WAIT_REFETCH,
    ERR_RESP
  } state_t;

  state_t                     state, state_nxt;
  logic [MEM_ADDR_BITS-1:0]   beat_addr, beat_nxt;
  logic [MEM_ADDR_BITS-1:0]   rd_idx, pred_addr, wrap_mask, beat_inc;
  logic [WB_DATA_WIDTH-1:0]   dat_r;
  logic [WB_DATA_WIDTH-1:0]   mem [DEPTH];
  logic                       rd_en, wr_en, ack, err;

  logic [WB_ADDR_WIDTH:0]     adr_diff;
  logic [WB_ADDR_WIDTH-1:0]   word_off;
  logic [MEM_ADDR_BITS-1:0]   adr_idx;
  logic                       adr_in_range, lin_overflow;

  // Borrow bit of the subtraction flags addresses below the window base.
  always_comb begin
    adr_diff     = {1'b0, wb.ADR} - {1'b0, BASE_ADDR};
    word_off     = adr_diff[WB_ADDR_WIDTH-1:0] >> OFF;
    adr_idx      = word_off[MEM_ADDR_BITS-1:0];
    adr_in_range = !adr_diff[WB_ADDR_WIDTH] && (word_off < DEPTH_W);
  end

  // Wrapping bursts increment only the low index bits inside the block.
  always_comb begin
    case (wb.BTE)
      2'b01:   wrap_mask = MEM_ADDR_BITS'(3);
      2'b10:   wrap_mask = MEM_ADDR_BITS'(7);
      2'b11:   wrap_mask = MEM_ADDR_BITS'(15);
      default: wrap_mask = '1;
    endcase
    beat_inc     = beat_addr + MEM_ADDR_BITS'(1);
    pred_addr    = (beat_addr & ~wrap_mask) | (beat_inc & wrap_mask);
    lin_overflow = (wb.BTE == 2'b00) && (&beat_addr);
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_addr;
    rd_en     = 1'b0;
    rd_idx    = beat_addr;
    ack       = 1'b0;
    err       = 1'b0;
    wr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (wb.CYC && wb.STB) begin
          if (!adr_in_range) begin
            state_nxt = ERR_RESP;
          end else begin
            rd_en     = 1'b1;
            rd_idx    = adr_idx;
            beat_nxt  = adr_idx;
            state_nxt = (wb.CTI == 3'b010) ? BURST : ACK_CLASSIC;
          end
        end
      end
      ACK_CLASSIC: begin
        if (!wb.CYC) begin
          state_nxt = IDLE;
        end else if (!wb.STB) begin
          rd_en = 1'b1;
        end else begin
          ack       = 1'b1;
          wr_en     = wb.WE;
          state_nxt = IDLE;
        end
      end
      BURST, WAIT_REFETCH: begin
        if (!wb.CYC) begin
          state_nxt = IDLE;
        end else if (!wb.STB) begin
          rd_en = 1'b1;
        end else if (!adr_in_range) begin
          state_nxt = ERR_RESP;
        end else if (adr_idx != beat_addr) begin
          // Master left the predicted sequence: fetch its address, ack next cycle.
          rd_en     = 1'b1;
          rd_idx    = adr_idx;
          beat_nxt  = adr_idx;
          state_nxt = WAIT_REFETCH;
        end else begin
          ack   = 1'b1;
          wr_en = wb.WE;
          if (wb.CTI == 3'b111) begin
            state_nxt = IDLE;
          end else if (lin_overflow) begin
            state_nxt = ERR_RESP;
          end else begin
            rd_en     = 1'b1;
            rd_idx    = pred_addr;
            beat_nxt  = pred_addr;
            state_nxt = BURST;
          end
        end
      end
      ERR_RESP: begin
        if (!wb.CYC) begin
          state_nxt = IDLE;
        end else if (wb.STB) begin
          err       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!rstn) begin
      ack   = 1'b0;
      err   = 1'b0;
      wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      beat_addr <= '0;
      dat_r     <= '0;
    end else begin
      state     <= state_nxt;
      beat_addr <= beat_nxt;
      if (rd_en) dat_r <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wb.SEL[b]) mem[beat_addr][8*b +: 8] <= wb.DAT_W[8*b +: 8];
      end
    end
  end

  assign wb.DAT_R = dat_r;
  assign wb.ACK   = ack;
  assign wb.ERR   = err;

endmodule

// File: tb/tb_wb_sram_burst_slave.sv
// Randomized self-checking bench for wb_sram_burst_slave: transaction-level
// master tasks predict ACK/ERR/DAT_R per cycle from a word-array memory model.
module tb_wb_sram_burst_slave;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned MB    = 10;
  localparam int          DEPTH = 2 ** MB;
  localparam logic [31:0] BASE  = 32'h0000_4000;

  logic clk = 1'b0;
  logic rstn;

  wb_sram_burst_slave_if #(.WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW)) bus ();

  wb_sram_burst_slave #(
    .WB_ADDR_WIDTH(AW),
    .WB_DATA_WIDTH(DW),
    .MEM_ADDR_BITS(MB),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .wb  (bus)
  );

  initial forever #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  bit          chk_on   = 1'b0;
  logic        exp_ack, exp_err, exp_dat_chk;
  logic [31:0] exp_dat;
  logic [31:0] last_dat;
  logic [31:0] model_mem [DEPTH];

  // Per-cycle compare against the expectations the master tasks set.
  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (bus.ACK !== exp_ack) begin
        failures++;
        $display("FAIL ack t=%0t got=%b exp=%b", $time, bus.ACK, exp_ack);
      end
      checks++;
      if (bus.ERR !== exp_err) begin
        failures++;
        $display("FAIL err t=%0t got=%b exp=%b", $time, bus.ERR, exp_err);
      end
      if (exp_ack && exp_dat_chk) begin
        checks++;
        if (bus.DAT_R !== exp_dat) begin
          failures++;
          $display("FAIL dat_r t=%0t got=%h exp=%h", $time, bus.DAT_R, exp_dat);
        end
      end
      if (bus.ACK) last_dat = bus.DAT_R;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wa(input int w);
    return BASE + 32'(w << 2);
  endfunction

  // Next beat word index from the burst-type rule.
  function automatic int nxt(input int w, input logic [1:0] bte);
    int m;
    if (bte == 2'b00) return w + 1;
    m = (bte == 2'b01) ? 3 : (bte == 2'b10) ? 7 : 15;
    return (w & ~m) | ((w + 1) & m);
  endfunction

  task automatic mwrite(input int w, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) model_mem[w][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic set_exp(input logic a, input logic e, input logic dc, input logic [31:0] d);
    exp_ack = a; exp_err = e; exp_dat_chk = dc; exp_dat = d;
  endtask

  task automatic set_bus(input logic cyc, input logic stb, input logic we, input logic [31:0] adr,
                         input logic [2:0] cti, input logic [1:0] bte,
                         input logic [31:0] d, input logic [3:0] s);
    bus.CYC = cyc; bus.STB = stb; bus.WE = we; bus.ADR = adr;
    bus.CTI = cti; bus.BTE = bte; bus.DAT_W = d; bus.SEL = s;
  endtask

  task automatic idle(input int n);
    bus.CYC = 1'b0; bus.STB = 1'b0;
    set_exp(0, 0, 0, '0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic classic(input logic [31:0] adr, input logic we, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] cti);
    logic [31:0] off;
    bit          inr;
    int          w;
    off = adr - BASE;
    inr = (adr >= BASE) && (off < 32'(DEPTH * 4));
    w   = int'(off >> 2);
    set_bus(1, 1, we, adr, cti, 2'b00, d, s);
    set_exp(0, 0, 0, '0);
    tick();
    if (inr) set_exp(1, 0, !we, model_mem[w]);
    else     set_exp(0, 1, 0, '0);
    tick();
    if (inr && we) mwrite(w, d, s);
  endtask

  task automatic burst(input int start, input logic [1:0] bte, input int n, input logic we,
                       input bit all_lanes, input int gap_beat, input int jump_beat,
                       input int jump_word, input int abort_beat, input bit abort_rst);
    int          w, pred;
    logic [31:0] d;
    logic [3:0]  s;
    logic [2:0]  cti;
    w    = start;
    pred = start;
    d    = $urandom;
    s    = all_lanes ? 4'hF : 4'($urandom);
    set_bus(1, 1, we, wa(w), (n == 1) ? 3'b111 : 3'b010, bte, d, s);
    set_exp(0, 0, 0, '0);
    tick();
    for (int i = 0; i < n; i++) begin
      cti = (i == n - 1) ? 3'b111 : 3'b010;
      if (i == gap_beat) begin
        bus.STB = 1'b0;
        set_exp(0, 0, 0, '0);
        tick();
      end
      set_bus(1, 1, we, wa(w), cti, bte, d, s);
      if (i == abort_beat) begin
        if (abort_rst) rstn = 1'b0;
        else           bus.CYC = 1'b0;
        set_exp(0, 0, 0, '0);
        tick();
        rstn = 1'b1;
        idle(1);
        return;
      end
      if (pred >= DEPTH) begin
        set_exp(0, 1, 0, '0);
        tick();
        break;
      end
      if (w != pred) begin
        set_exp(0, 0, 0, '0);
        tick();
        pred = w;
      end
      set_exp(1, 0, !we, model_mem[w]);
      tick();
      if (we) mwrite(w, d, s);
      pred = nxt(w, bte);
      w    = (i + 1 == jump_beat) ? jump_word : pred;
      d    = $urandom;
      s    = all_lanes ? 4'hF : 4'($urandom);
    end
    idle(1);
  endtask

  initial begin
    int          n, gb, jb;
    logic [2:0]  cti;
    logic [31:0] adr;

    rstn = 1'b0;
    set_bus(0, 0, 0, '0, 3'b000, 2'b00, '0, '0);
    set_exp(0, 0, 0, '0);
    tick(); tick();
    chk_on = 1'b1;
    tick();
    check("rst_ack", {31'b0, bus.ACK}, 32'd0);
    check("rst_err", {31'b0, bus.ERR}, 32'd0);
    check("rst_dat_r", bus.DAT_R, 32'd0);
    rstn = 1'b1;
    idle(1);

    check("nxt_lin", 32'(nxt(5, 2'b00)), 32'd6);
    check("nxt_wrap4", 32'(nxt(3, 2'b01)), 32'd0);
    check("nxt_wrap8", 32'(nxt(15, 2'b10)), 32'd8);
    check("nxt_wrap16", 32'(nxt(31, 2'b11)), 32'd16);

    burst(0, 2'b00, DEPTH, 1, 1, -1, -1, 0, -1, 0);

    classic(BASE + 32'h10, 1, 32'hDEADBEEF, 4'hF, 3'b000);
    classic(BASE + 32'h10, 0, '0, 4'hF, 3'b000);
    check("classic_rd", last_dat, 32'hDEADBEEF);
    idle(1);

    classic(BASE + 32'h14, 1, 32'h11223344, 4'hF, 3'b000);
    classic(BASE + 32'h14, 1, 32'hAABBCCDD, 4'h5, 3'b000);
    classic(BASE + 32'h14, 0, '0, 4'hF, 3'b000);
    check("byte_lanes", last_dat, 32'h11BB33DD);
    idle(1);

    for (int i = 0; i < 4; i++) classic(wa(i), 1, 32'hA000_0000 + 32'(i), 4'hF, 3'b000);
    classic(wa(8), 1, 32'h8888_8888, 4'hF, 3'b000);
    idle(1);

    burst(0, 2'b00, 4, 0, 1, -1, -1, 0, -1, 0);
    check("lin_burst_last", last_dat, 32'hA000_0003);
    burst(2, 2'b01, 4, 0, 1, -1, -1, 0, -1, 0);
    check("wrap4_last", last_dat, 32'hA000_0001);
    burst(2, 2'b01, 4, 0, 1, 2, -1, 0, -1, 0);
    check("wrap4_gap_last", last_dat, 32'hA000_0001);

    classic(BASE + 32'(DEPTH * 4), 0, '0, 4'hF, 3'b000);
    idle(1);
    classic(BASE - 32'd4, 0, '0, 4'hF, 3'b000);
    idle(1);
    burst(DEPTH - 1, 2'b00, 2, 0, 1, -1, -1, 0, -1, 0);
    burst(0, 2'b00, 3, 0, 1, -1, 2, 8, -1, 0);
    check("jump_last", last_dat, 32'h8888_8888);

    classic(wa(22), 1, 32'h5555_AAAA, 4'hF, 3'b000);
    idle(1);
    burst(20, 2'b00, 4, 1, 1, -1, -1, 0, 2, 0);
    classic(wa(22), 0, '0, 4'hF, 3'b000);
    check("abort_cyc_word", last_dat, 32'h5555_AAAA);
    idle(1);
    burst(20, 2'b00, 4, 1, 1, -1, -1, 0, 2, 1);
    classic(wa(22), 0, '0, 4'hF, 3'b000);
    check("abort_rst_word", last_dat, 32'h5555_AAAA);
    idle(1);

    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 9))
          0:       adr = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 63));
          1:       adr = BASE - 32'($urandom_range(1, 64));
          default: adr = wa($urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
        endcase
        cti = 3'($urandom_range(0, 7));
        if (cti == 3'b010) cti = 3'b000;
        classic(adr, 1'($urandom), $urandom, 4'($urandom), cti);
      end else begin
        n  = $urandom_range(1, 16);
        gb = (n > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : -1;
        jb = (n > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : -1;
        burst($urandom_range(0, DEPTH - 1), 2'($urandom), n, 1'($urandom), 0,
              gb, jb, $urandom_range(0, DEPTH - 1), -1, 0);
      end
      idle($urandom_range(0, 2));
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
